// File: rtl/read_return_reorder_pkg.sv
// Shared types and constants for the read-return reorder path.
//
// Holds the configuration constants (data/address widths, reorder depth, permutation offset),
// the completion record and the return-FSM state encoding used by read_return_reorder and its
// address unmapper.
//
// Mapped address layout produced by the request mapper (and consumed by the unmapper):
//   [29:14] row   [13:12] bank   [11:10] bank_group   [9:0] column
// where bank / bank_group were XOR-folded with row bits at offset T.
package read_return_reorder_pkg;

  localparam int unsigned DataWidth      = 32;
  localparam int unsigned AddressWidth   = 30;
  localparam int unsigned ReadEntries    = 64;
  localparam int unsigned ReadEntriesLog = 6;
  localparam int unsigned T              = 5;

  typedef logic [AddressWidth-1:0]   address_type;
  typedef logic [DataWidth-1:0]      data_t;
  typedef logic [ReadEntriesLog-1:0] index_t;

  typedef enum logic {
    RTypeRead  = 1'b0,
    RTypeWrite = 1'b1
  } r_type;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StReset   = 2'd2
  } state_e;

  typedef struct packed {
    r_type       req_type;
    index_t      index;
    data_t       data;
    address_type address;
  } completion_t;

  // Reorder index successor; wraps naturally at ReadEntries.
  function automatic index_t next_index(index_t idx);
    return idx + index_t'(1);
  endfunction

endpackage

// File: rtl/read_return_reorder_if.sv
// Completion / return bundle between the bank scheduler, the reorder block and the RNIC.
//
// Signals:
//   cmp_valid/cmp_type/cmp_index/cmp_data/cmp_addr  completion from the scheduler side
//   rnic_ready                                      RNIC accepts the current return beat
//   ret_valid/ret_data/ret_index/ret_addr           in-order return beat to the RNIC
//   wr_ack, read_free, write_free                   single-cycle pulses
//   dup_err                                         sticky duplicate-completion flag
// Modports: slave = the reorder block, master = the environment driving it.
interface read_return_reorder_if;
  import read_return_reorder_pkg::*;

  logic        cmp_valid;
  r_type       cmp_type;
  index_t      cmp_index;
  data_t       cmp_data;
  address_type cmp_addr;
  logic        rnic_ready;

  logic        ret_valid;
  data_t       ret_data;
  index_t      ret_index;
  address_type ret_addr;
  logic        wr_ack;
  logic        read_free;
  logic        write_free;
  logic        dup_err;

  modport slave (
    input  cmp_valid, cmp_type, cmp_index, cmp_data, cmp_addr, rnic_ready,
    output ret_valid, ret_data, ret_index, ret_addr, wr_ack, read_free, write_free, dup_err
  );

  modport master (
    output cmp_valid, cmp_type, cmp_index, cmp_data, cmp_addr, rnic_ready,
    input  ret_valid, ret_data, ret_index, ret_addr, wr_ack, read_free, write_free, dup_err
  );

endinterface

// File: rtl/read_return_reorder_addr_unmapper.sv
// Pure combinational inverse of the request mapper's address permutation.
//
// Ports:
//   mapped_i    address as issued by the mapper ({row, bank, bank_group, column})
//   unmapped_o  original RNIC-side address
// The bank and bank_group fields were XORed with row bits at offset T; the row is passed
// through unchanged, so those same bits are available here to undo the fold.
// Only instantiated when RET_ADDR_EN is defined.
module read_return_reorder_addr_unmapper
  import read_return_reorder_pkg::*;
#(
  parameter int unsigned Offset = T
) (
  input  address_type mapped_i,
  output address_type unmapped_o
);

  localparam int unsigned Msb = AddressWidth - 1;

  always_comb begin
    unmapped_o        = '0;
    unmapped_o[29:14] = mapped_i[29:14];
    unmapped_o[13:12] = mapped_i[13:12] ^ mapped_i[Msb-Offset+1 -: 2];
    unmapped_o[11:6]  = mapped_i[9:4];
    unmapped_o[5:4]   = mapped_i[11:10] ^ mapped_i[Msb-Offset+3 -: 2];
    unmapped_o[3:0]   = mapped_i[3:0];
  end

endmodule

// File: rtl/read_return_reorder.sv
// Return path of the TXN controller: reorders tagged read completions back into index order.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active low
//   bus   read_return_reorder_if.slave (completions in, in-order return beats out, pulses)
// Read completions are written into a ReadEntries-deep buffer at their mapper index; the head
// entry is returned to the RNIC through a registered beat, one beat per cycle when the next
// entry is already present. Write completions are only acknowledged (wr_ack / write_free).
// A completion to an entry that is still valid is dropped and sets the sticky dup_err.
//
// Optional feature: define RET_ADDR_EN to also buffer cmp_addr per entry and return the
// unmapped RNIC address on ret_addr; otherwise ret_addr is tied to zero.
module read_return_reorder
  import read_return_reorder_pkg::*;
(
  input logic               clk,
  input logic               rst,
  read_return_reorder_if.slave bus
);

  state_e                 state_q, state_d;
  logic [ReadEntries-1:0] valid_q, valid_d;
  data_t                  data_q [ReadEntries];
  data_t                  data_d [ReadEntries];
  index_t                 head_q, head_d;
  data_t                  ret_data_q, ret_data_d;
  index_t                 ret_index_q, ret_index_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   read_free_q, read_free_d;
  logic                   write_free_q, write_free_d;
  logic                   dup_err_q, dup_err_d;

  completion_t cmp;
  logic        cmp_read, cmp_write;
  logic        store, dup, accept, load, bypass, ret_valid;
  index_t      head_inc, load_idx;

  assign cmp = '{
    req_type: bus.cmp_type,
    index:    bus.cmp_index,
    data:     bus.cmp_data,
    address:  bus.cmp_addr
  };

  // Completion classification. A read to an entry still marked valid (including the head
  // being released this very cycle) is a duplicate.
  always_comb begin
    cmp_read  = bus.cmp_valid && (cmp.req_type == RTypeRead);
    cmp_write = bus.cmp_valid && (cmp.req_type == RTypeWrite);
    dup       = cmp_read && valid_q[cmp.index];
    store     = cmp_read && !valid_q[cmp.index];
  end

  assign accept   = ret_valid && bus.rnic_ready;
  assign head_inc = next_index(head_q);

  // Next-state valid bits: they already include this cycle's store, so a completion for
  // head+1 arriving together with the head handshake still sustains back-to-back beats.
  always_comb begin
    valid_d = valid_q;
    if (accept) valid_d[head_q] = 1'b0;
    if (store)  valid_d[cmp.index] = 1'b1;
  end

  always_comb begin
    data_d = data_q;
    if (store) data_d[cmp.index] = cmp.data;
  end

  assign head_d = accept ? head_inc : head_q;

  // ---------------------------------------------------------------------------------------
  // Return FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // load: capture a new beat into the output register, from entry load_idx.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = head_q;
    unique case (state_q)
      StReset: state_d = StIdle;
      StIdle: begin
        if (valid_q[head_q]) begin
          state_d = StPresent;
          load    = 1'b1;
        end
      end
      StPresent: begin
        if (accept) begin
          if (valid_d[head_inc]) begin
            load     = 1'b1;
            load_idx = head_inc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ret_valid = (state_q == StPresent);
  end

  // ---------------------------------------------------------------------------------------
  // Output beat register and pulses
  // ---------------------------------------------------------------------------------------
  // Bypass covers the head+1 entry being written in the same cycle it is loaded.
  always_comb begin
    bypass      = store && (cmp.index == load_idx);
    ret_data_d  = ret_data_q;
    ret_index_d = ret_index_q;
    if (load) begin
      ret_data_d  = bypass ? cmp.data : data_q[load_idx];
      ret_index_d = load_idx;
    end
  end

  always_comb begin
    wr_ack_d     = cmp_write;
    write_free_d = cmp_write;
    read_free_d  = accept;
    dup_err_d    = dup_err_q | dup;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      head_q       <= '0;
      ret_data_q   <= '0;
      ret_index_q  <= '0;
      wr_ack_q     <= 1'b0;
      read_free_q  <= 1'b0;
      write_free_q <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      head_q       <= head_d;
      ret_data_q   <= ret_data_d;
      ret_index_q  <= ret_index_d;
      wr_ack_q     <= wr_ack_d;
      read_free_q  <= read_free_d;
      write_free_q <= write_free_d;
      dup_err_q    <= dup_err_d;
    end
  end

  // Buffer contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

`ifdef RET_ADDR_EN
  address_type addr_q [ReadEntries];
  address_type addr_d [ReadEntries];
  address_type ret_addr_q, ret_addr_d;
  address_type sel_addr, unmapped;

  always_comb begin
    addr_d = addr_q;
    if (store) addr_d[cmp.index] = cmp.address;
  end

  // Entries keep the mapped address; only the selected one is unmapped on its way out.
  assign sel_addr = bypass ? cmp.address : addr_q[load_idx];

  read_return_reorder_addr_unmapper #(
    .Offset(T)
  ) u_addr_unmapper (
    .mapped_i  (sel_addr),
    .unmapped_o(unmapped)
  );

  assign ret_addr_d = load ? unmapped : ret_addr_q;

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ret_addr_q <= '0;
    end else begin
      ret_addr_q <= ret_addr_d;
    end
  end

  assign bus.ret_addr = ret_addr_q;
`else
  assign bus.ret_addr = '0;
`endif

  assign bus.ret_valid  = ret_valid;
  assign bus.ret_data   = ret_data_q;
  assign bus.ret_index  = ret_index_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.read_free  = read_free_q;
  assign bus.write_free = write_free_q;
  assign bus.dup_err    = dup_err_q;

endmodule

// File: tb/tb_read_return_reorder.sv
// Self-checking bench for read_return_reorder: directed scenarios plus randomized rounds,
// checked against a buffer-and-head reference model. Honors RET_ADDR_EN for ret_addr.
module tb_read_return_reorder;
  import read_return_reorder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_return_reorder_if bus ();

  read_return_reorder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: what is buffered per index, and which index must come out next.
  data_t       m_data  [ReadEntries];
  address_type m_raddr [ReadEntries];
  bit          m_valid [ReadEntries];
  index_t      m_head;
  bit          m_dup;
  int          n_beats, n_free, n_ack, n_wfree, n_writes;
  address_type cur_raddr;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forward mapper equations (what the request mapper applies to RNIC addresses).
  function automatic address_type map_fwd(address_type a);
    address_type m;
    m[29:14] = a[29:14];
    m[13:12] = a[13:12] ^ a[29-T+1 -: 2];
    m[11:10] = a[5:4] ^ a[29-T+3 -: 2];
    m[9:4]   = a[11:6];
    m[3:0]   = a[3:0];
    return m;
  endfunction

  function automatic address_type exp_ret_addr(address_type raddr);
`ifdef RET_ADDR_EN
    return raddr;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ReadEntries; i++) m_valid[i] = 1'b0;
    m_head   = '0;
    m_dup    = 1'b0;
    n_beats  = 0;
    n_free   = 0;
    n_ack    = 0;
    n_wfree  = 0;
    n_writes = 0;
  endtask

  // One clock: score any beat handed over at this edge, update the model, advance.
  task automatic cyc();
    bit acc;
    acc = (bus.ret_valid === 1'b1) && (bus.rnic_ready === 1'b1);
    if (acc) begin
      check("beat_index", 64'(bus.ret_index), 64'(m_head));
      check("beat_data", 64'(bus.ret_data), 64'(m_data[m_head]));
      check("beat_addr", 64'(bus.ret_addr), 64'(exp_ret_addr(m_raddr[m_head])));
      check("beat_buffered", 64'(m_valid[m_head]), 64'd1);
    end
    if (bus.cmp_valid && bus.cmp_type == RTypeRead) begin
      if (m_valid[bus.cmp_index]) begin
        m_dup = 1'b1;
      end else begin
        m_valid[bus.cmp_index] = 1'b1;
        m_data[bus.cmp_index]  = bus.cmp_data;
        m_raddr[bus.cmp_index] = cur_raddr;
      end
    end
    if (bus.cmp_valid && bus.cmp_type == RTypeWrite) n_writes++;
    if (acc) begin
      m_valid[m_head] = 1'b0;
      m_head++;
      n_beats++;
    end
    @(posedge clk);
    #1;
    if (bus.read_free === 1'b1) n_free++;
    if (bus.wr_ack === 1'b1) n_ack++;
    if (bus.write_free === 1'b1) n_wfree++;
    bus.cmp_valid = 1'b0;
  endtask

  task automatic send_read(index_t idx, data_t d, address_type raddr);
    bus.cmp_valid = 1'b1;
    bus.cmp_type  = RTypeRead;
    bus.cmp_index = idx;
    bus.cmp_data  = d;
    bus.cmp_addr  = map_fwd(raddr);
    cur_raddr     = raddr;
    cyc();
  endtask

  task automatic send_write();
    bus.cmp_valid = 1'b1;
    bus.cmp_type  = RTypeWrite;
    bus.cmp_index = index_t'($urandom_range(0, ReadEntries - 1));
    bus.cmp_data  = data_t'($urandom);
    bus.cmp_addr  = '0;
    cyc();
  endtask

  task automatic drain(string tag, int target, int budget);
    int k;
    k = 0;
    bus.rnic_ready = 1'b1;
    while (n_beats < target && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 64'(n_beats), 64'(target));
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.cmp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_ret_valid"}, 64'(bus.ret_valid), 64'd0);
    check({tag, "_ret_data"}, 64'(bus.ret_data), 64'd0);
    check({tag, "_ret_index"}, 64'(bus.ret_index), 64'd0);
    check({tag, "_ret_addr"}, 64'(bus.ret_addr), 64'd0);
    check({tag, "_wr_ack"}, 64'(bus.wr_ack), 64'd0);
    check({tag, "_read_free"}, 64'(bus.read_free), 64'd0);
    check({tag, "_write_free"}, 64'(bus.write_free), 64'd0);
    check({tag, "_dup_err"}, 64'(bus.dup_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    index_t order [ReadEntries];
    rst            = 1'b0;
    bus.cmp_valid  = 1'b0;
    bus.cmp_type   = RTypeRead;
    bus.cmp_index  = '0;
    bus.cmp_data   = '0;
    bus.cmp_addr   = '0;
    bus.rnic_ready = 1'b0;
    cur_raddr      = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state.
    do_reset();
    check_quiet("reset");

    // Out-of-order completions 2,0,1 return as 0,1,2 on consecutive cycles.
    do_reset();
    bus.rnic_ready = 1'b1;
    send_read(2, 32'hA2A2_A2A2, address_type'($urandom));
    send_read(0, 32'hB0B0_B0B0, address_type'($urandom));
    check("ooo_idle_after_store", 64'(bus.ret_valid), 64'd0);
    send_read(1, 32'hC1C1_C1C1, address_type'($urandom));
    check("ooo_beat0_valid", 64'(bus.ret_valid), 64'd1);
    check("ooo_beat0_data", 64'(bus.ret_data), 64'hB0B0_B0B0);
    cyc();
    check("ooo_beat1_valid", 64'(bus.ret_valid), 64'd1);
    check("ooo_beat1_data", 64'(bus.ret_data), 64'hC1C1_C1C1);
    cyc();
    check("ooo_beat2_data", 64'(bus.ret_data), 64'hA2A2_A2A2);
    check("ooo_beat2_index", 64'(bus.ret_index), 64'd2);
    cyc();
    check("ooo_back_to_idle", 64'(bus.ret_valid), 64'd0);
    check("ooo_read_free_count", 64'(n_free), 64'd3);

    // Backpressure holds the beat stable.
    do_reset();
    bus.rnic_ready = 1'b0;
    send_read(0, 32'hD0D0_0001, address_type'($urandom));
    cyc();
    check("bp_valid_first", 64'(bus.ret_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_hold_valid", 64'(bus.ret_valid), 64'd1);
      check("bp_hold_data", 64'(bus.ret_data), 64'hD0D0_0001);
    end
    bus.rnic_ready = 1'b1;
    cyc();
    check("bp_accepted", 64'(n_beats), 64'd1);
    check("bp_read_free", 64'(bus.read_free), 64'd1);
    check("bp_idle_after", 64'(bus.ret_valid), 64'd0);
    send_read(1, 32'hD0D0_0002, address_type'($urandom));
    drain("bp_head_is_1", 2, 10);

    // 64 in-order completions then index 0 again: head wraps.
    do_reset();
    bus.rnic_ready = 1'b1;
    for (int i = 0; i < ReadEntries; i++) begin
      send_read(index_t'(i), data_t'($urandom), address_type'($urandom));
    end
    send_read(0, 32'h0DD0_0065, address_type'($urandom));
    drain("wrap_65_beats", 65, 20);
    check("wrap_head", 64'(m_head), 64'd1);
    check("wrap_read_free", 64'(n_free), 64'd65);
    check("wrap_no_dup", 64'(bus.dup_err), 64'd0);

    // Duplicate completion keeps first data; write completion pulses once.
    do_reset();
    bus.rnic_ready = 1'b0;
    send_read(5, 32'h5555_F1F1, address_type'($urandom));
    check("dup_not_yet", 64'(bus.dup_err), 64'd0);
    send_read(5, 32'h5555_5EC0, address_type'($urandom));
    check("dup_set", 64'(bus.dup_err), 64'd1);
    send_write();
    check("wr_ack_pulse", 64'(bus.wr_ack), 64'd1);
    check("write_free_pulse", 64'(bus.write_free), 64'd1);
    cyc();
    check("wr_ack_drop", 64'(bus.wr_ack), 64'd0);
    check("write_free_drop", 64'(bus.write_free), 64'd0);
    for (int i = 0; i < 5; i++) send_read(index_t'(i), data_t'($urandom), address_type'($urandom));
    drain("dup_drain", 6, 20);
    check("dup_sticky", 64'(bus.dup_err), 64'd1);
    check("dup_wr_ack_count", 64'(n_ack), 64'd1);

    // Reset with a beat presented drops everything.
    do_reset();
    bus.rnic_ready = 1'b0;
    send_read(0, data_t'($urandom), address_type'($urandom));
    send_read(1, data_t'($urandom), address_type'($urandom));
    send_read(2, data_t'($urandom), address_type'($urandom));
    check("midrst_presenting", 64'(bus.ret_valid), 64'd1);
    do_reset();
    check_quiet("midrst");
    send_read(0, 32'h2E5E_7000, address_type'($urandom));
    drain("midrst_after", 1, 10);
    repeat (3) cyc();
    check("midrst_old_entries_gone", 64'(n_beats), 64'd1);

    // Address return path.
    do_reset();
    bus.rnic_ready = 1'b0;
    send_read(0, 32'hADD0_0000, 30'h2ABC_1234);
    cyc();
    check("addr_return", 64'(bus.ret_addr), 64'(exp_ret_addr(30'h2ABC_1234)));
    drain("addr_drain", 1, 10);

    // Randomized rounds: shuffled completions, random gaps, writes and backpressure.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int n;
      int target;
      n      = $urandom_range(1, ReadEntries);
      target = n_beats + n;
      for (int i = 0; i < n; i++) order[i] = m_head + index_t'(i);
      for (int i = n - 1; i > 0; i--) begin
        int j;
        index_t tmp;
        j        = $urandom_range(0, i);
        tmp      = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.rnic_ready = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 0) send_write();
          else cyc();
        end
        bus.rnic_ready = ($urandom_range(0, 3) != 0);
        send_read(order[i], data_t'($urandom), address_type'($urandom));
      end
      drain("rand_round_drain", target, 3 * ReadEntries);
    end
    cyc();
    check("rand_wr_ack_count", 64'(n_ack), 64'(n_writes));
    check("rand_write_free_count", 64'(n_wfree), 64'(n_writes));
    check("rand_read_free_count", 64'(n_free), 64'(n_beats));
    check("rand_dup_err", 64'(bus.dup_err), 64'(m_dup));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
